// File: rtl/axi_lite_ctrl.sv
// AXI4-Lite slave holding the MODE and ADD_VALUE configuration registers
// for the stream processor; reserved slots at 0x8/0xC read as zero.
module axi_lite_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  s_axi_awvalid,
    input  logic [3:0]            s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    output logic                  s_axi_awready,
    output logic                  s_axi_wready,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic                  s_axi_arvalid,
    input  logic [3:0]            s_axi_araddr,
    output logic                  s_axi_arready,
    output logic                  s_axi_rvalid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] ctrl_mode,
    output logic [DATA_WIDTH-1:0] ctrl_add_value
);

    localparam logic [1:0] ADDR_MODE = 2'd0;
    localparam logic [1:0] ADDR_ADD  = 2'd1;

    logic [DATA_WIDTH-1:0] mode_q, mode_d;
    logic [DATA_WIDTH-1:0] add_q, add_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  ar_ready;

    assign wr_accept = s_axi_awvalid & s_axi_wvalid & ~s_axi_areset;
    assign ar_ready  = ~s_axi_areset & (~rvalid_q | s_axi_rready);
    assign rd_accept = s_axi_arvalid & ar_ready;

    // Read mux sees the registered values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        unique case (s_axi_araddr[3:2])
            ADDR_MODE: rd_mux = mode_q;
            ADDR_ADD:  rd_mux = add_q;
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        add_d  = add_q;
        if (wr_accept) begin
            unique case (s_axi_awaddr[3:2])
                ADDR_MODE: mode_d = s_axi_wdata;
                ADDR_ADD:  add_d  = s_axi_wdata;
                default:   ;
            endcase
        end
    end

    // Back-to-back write responses merge into one pending flag.
    always_comb begin
        bvalid_d = wr_accept | (bvalid_q & ~s_axi_bready);
        rvalid_d = rd_accept | (rvalid_q & ~s_axi_rready);
        rdata_d  = rd_accept ? rd_mux : rdata_q;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            mode_q   <= '0;
            add_q    <= '0;
            rdata_q  <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            add_q    <= add_d;
            rdata_q  <= rdata_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign s_axi_awready  = wr_accept;
    assign s_axi_wready   = wr_accept;
    assign s_axi_arready  = ar_ready;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = rdata_q;
    assign ctrl_mode      = mode_q;
    assign ctrl_add_value = add_q;

endmodule

// File: tb/tb_axi_lite_ctrl.sv
// Bench for axi_lite_ctrl: directed steps then random traffic, all checked
// against a register-map model of the slave.
module tb_axi_lite_ctrl;

    logic        clk = 1'b0;
    logic        areset;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata, ctrl_mode, ctrl_add_value;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_regs [4];
    logic        m_bpend;
    logic        m_rpend;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    axi_lite_ctrl #(.DATA_WIDTH(32)) dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (areset),
        .s_axi_awvalid  (awvalid),
        .s_axi_awaddr   (awaddr),
        .s_axi_wvalid   (wvalid),
        .s_axi_wdata    (wdata),
        .s_axi_awready  (awready),
        .s_axi_wready   (wready),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_arvalid  (arvalid),
        .s_axi_araddr   (araddr),
        .s_axi_arready  (arready),
        .s_axi_rvalid   (rvalid),
        .s_axi_rdata    (rdata),
        .s_axi_rready   (rready),
        .ctrl_mode      (ctrl_mode),
        .ctrl_add_value (ctrl_add_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        areset  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        awaddr  = 4'h0;
        wdata   = 32'h0;
        bready  = 1'b0;
        arvalid = 1'b0;
        araddr  = 4'h0;
        rready  = 1'b0;
    endtask

    // One clock: check readies, advance the model, check registered outputs.
    task automatic cycle();
        logic wr, ar;
        int   idx;
        #1;
        wr = awvalid & wvalid & ~areset;
        ar = arvalid & ~areset & (~m_rpend | rready);
        chk("awready", {31'b0, awready}, {31'b0, wr});
        chk("wready", {31'b0, wready}, {31'b0, wr});
        chk("arready", {31'b0, arready},
            {31'b0, ~areset & (~m_rpend | rready)});
        if (areset) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_bpend = 1'b0;
            m_rpend = 1'b0;
            m_rdata = 32'h0;
        end else begin
            if (ar) begin
                m_rdata = m_regs[int'(araddr) / 4];
                m_rpend = 1'b1;
            end else if (rready) begin
                m_rpend = 1'b0;
            end
            if (wr) begin
                idx = int'(awaddr) / 4;
                if (idx < 2) m_regs[idx] = wdata;
                m_bpend = 1'b1;
            end else if (bready) begin
                m_bpend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ctrl_mode", ctrl_mode, m_regs[0]);
        chk("ctrl_add_value", ctrl_add_value, m_regs[1]);
        chk("bvalid", {31'b0, bvalid}, {31'b0, m_bpend});
        chk("rvalid", {31'b0, rvalid}, {31'b0, m_rpend});
        chk("rdata", rdata, m_rdata);
        @(negedge clk);
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = a;
        wdata   = d;
        cycle();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic read(input logic [3:0] a);
        arvalid = 1'b1;
        araddr  = a;
        cycle();
        arvalid = 1'b0;
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_bpend = 1'b0;
        m_rpend = 1'b0;
        m_rdata = 32'h0;
        idle();
        areset = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        areset = 1'b0;
        cycle();

        write(4'h0, 32'h0000_0002);
        chk("mode_written", ctrl_mode, 32'h0000_0002);
        cycle();
        chk("bvalid_held", {31'b0, bvalid}, 32'h1);

        write(4'h4, 32'h1234_5678);
        chk("add_written", ctrl_add_value, 32'h1234_5678);
        bready = 1'b1;
        cycle();
        bready = 1'b0;
        chk("bvalid_cleared", {31'b0, bvalid}, 32'h0);

        rready = 1'b1;
        read(4'h0);
        chk("rd_mode", rdata, 32'h0000_0002);
        read(4'h4);
        chk("rd_add", rdata, 32'h1234_5678);
        cycle();

        rready = 1'b0;
        read(4'h4);
        arvalid = 1'b1;
        araddr  = 4'h0;
        cycle();
        cycle();
        chk("rd_stall_hold", rdata, 32'h1234_5678);
        rready = 1'b1;
        cycle();
        chk("rd_after_stall", rdata, 32'h0000_0002);
        arvalid = 1'b0;
        cycle();

        write(4'hC, 32'hDEAD_BEEF);
        bready = 1'b1;
        read(4'h8);
        chk("rd_reserved", rdata, 32'h0);
        cycle();
        awvalid = 1'b1;
        awaddr  = 4'h0;
        wdata   = 32'hFFFF_FFFF;
        repeat (3) cycle();
        awvalid = 1'b0;
        chk("lone_aw_mode", ctrl_mode, 32'h0000_0002);

        // Same-cycle read and write to MODE returns the old value.
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = 4'h1;
        wdata   = 32'hA5A5_0001;
        arvalid = 1'b1;
        araddr  = 4'h2;
        cycle();
        idle();
        chk("rw_same_old", rdata, 32'h0000_0002);

        // Reset in the middle of pending responses.
        write(4'h4, 32'h0BAD_F00D);
        read(4'h4);
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        cycle();

        for (int i = 0; i < 400; i++) begin
            areset  = ($urandom_range(0, 59) == 0);
            awvalid = $urandom_range(0, 1) == 1;
            wvalid  = $urandom_range(0, 1) == 1;
            awaddr  = 4'($urandom_range(0, 15));
            wdata   = $urandom;
            bready  = $urandom_range(0, 2) != 0;
            arvalid = $urandom_range(0, 1) == 1;
            araddr  = 4'($urandom_range(0, 15));
            rready  = $urandom_range(0, 2) != 0;
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/axi_lite_ctrl.md
Name: axi_lite_ctrl

Overview:
- AXI4-Lite slave register block that holds the run-time configuration of the AXI-Stream processor datapath.
- Provides two read/write 32-bit registers, MODE and ADD_VALUE, plus two reserved read-as-zero slots, in a 16-byte address window.
- Register contents drive the processor through dedicated output ports.
- Simplified AXI-Lite subset: no WSTRB, BRESP, RRESP or PROT signals.

Parameters:
- DATA_WIDTH, 32, width of the write/read data bus and of every register.

Ports:
- s_axi_aclk  in  1  clock; all logic on the rising edge.
- s_axi_areset  in  1  synchronous reset, active-high.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awaddr  in  4  write byte address.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_awready  out  1  write address ready.
- s_axi_wready  out  1  write data ready.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_araddr  in  4  read byte address.
- s_axi_arready  out  1  read address ready.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rready  in  1  read data ready.
- ctrl_mode  out  DATA_WIDTH  current MODE register.
- ctrl_add_value  out  DATA_WIDTH  current ADD_VALUE register.

Behaviour:
- Clock and reset: one clock (s_axi_aclk); reset is synchronous and active-high (s_axi_areset).
- Reset: MODE=0, ADD_VALUE=0, bvalid=0, rvalid=0, rdata=0. awready, wready and arready are 0 while s_axi_areset=1.
- Address map (decoded from addr[3:2]; addr[1:0] ignored):
  - 0x0: MODE (R/W).
  - 0x4: ADD_VALUE (R/W).
  - 0x8, 0xC: reserved; read 0, writes ignored.
- Write channel:
  - awready = wready = awvalid & wvalid (combinational, gated by reset).
  - A write is accepted only when both valids are high in the same cycle. A lone awvalid or wvalid waits with no ready.
  - On acceptance, the addressed register updates at that rising edge and is visible on ctrl_* and to reads from the next cycle.
  - bvalid rises in the cycle after acceptance.
- Write response:
  - bvalid stays high until a cycle with bready=1 and no new write accepted; it then clears at that edge.
  - Writes are never stalled by a pending response. Responses for back-to-back writes coalesce into the single bvalid flag.
  - If a write is accepted in the same cycle bready=1, bvalid stays 1.
- Read channel:
  - arready = !rvalid | rready (gated by reset).
  - On arvalid & arready, rdata is registered with the addressed value and rvalid=1 on the next cycle (1-cycle latency).
  - rvalid/rdata hold until rready=1, then rvalid clears unless a new read is accepted in that same cycle. Back-to-back reads with rready=1 sustain one read per cycle.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Reset asserted mid-transaction drops any pending bvalid/rvalid and restores reset values at that edge.
- All register bits are stored in full DATA_WIDTH; no field masking.

Test Plan:
- Reset then idle: hold areset=1 for 2 cycles -> all ready/valid outputs 0, ctrl_mode=0, ctrl_add_value=0.
- Write MODE: awvalid=wvalid=1, awaddr=0x0, wdata=0x02 for one cycle -> awready=wready=1 that cycle; ctrl_mode=0x00000002 next cycle; bvalid=1 and held while bready=0.
- Write ADD_VALUE with bvalid still pending: awaddr=0x4, wdata=0x12345678 for one cycle -> accepted; ctrl_add_value=0x12345678; bvalid stays 1; bready=1 for one cycle -> bvalid=0.
- Read back with rready=1: araddr=0x0 for one cycle -> rvalid=1 next cycle with rdata=0x00000002. Then araddr=0x4 -> rdata=0x12345678.
- Read stall: rready=0, read 0x4 -> rvalid and rdata held, arready=0. A second arvalid is not accepted until rready=1.
- Reserved/partial: write 0xDEADBEEF to 0xC -> no register changes; read 0x8 -> rdata=0. Lone awvalid without wvalid for 3 cycles -> no ready, no bvalid.
